// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: request, HI/LO write and result bundle of the mul/div unit.
// Master issues operations and mthi/mtlo writes; slave returns status and HI/LO.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dz;

  modport master (
    output start, op, in1, in2,
    output wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo, dz
  );

  modport slave (
    input  start, op, in1, in2,
    input  wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo, dz
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative HI/LO multiply/divide unit (shift-add, restoring).
// One bit per cycle on magnitudes; signs are applied once in the FIX state.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mc_q;
  logic               div_q;
  logic               qneg_q;
  logic               rneg_q;
  logic               dzp_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               accept;
  logic               is_div;
  logic               s1;
  logic               s2;
  logic               zdiv;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;

  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     rsh;
  logic               rge;
  logic [WIDTH-1:0]   rsub;
  logic [2*WIDTH-1:0] acc_d;

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  // Request decode: accept, operand signs and magnitudes.
  always_comb begin
    accept = bus.start && (state_q == IDLE)
          && (bus.op[3:2] == 2'b11);
    is_div = bus.op[0];
    s1     = bus.op[1] & bus.in1[WIDTH-1];
    s2     = bus.op[1] & bus.in2[WIDTH-1];
    zdiv   = is_div && (bus.in2 == '0);
    mag1   = s1 ? -bus.in1 : bus.in1;
    mag2   = s2 ? -bus.in2 : bus.in2;
  end

  // One multiply or divide step on the shared accumulator.
  always_comb begin
    msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
         + (acc_q[0] ? {1'b0, mc_q} : '0);
    rsh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rge  = rsh >= {1'b0, mc_q};
    rsub = rsh[WIDTH-1:0] - mc_q;
    if (!div_q) begin
      acc_d = {msum, acc_q[WIDTH-1:1]};
    end else if (rge) begin
      acc_d = {rsub, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign-corrected results presented to HI/LO in FIX.
  always_comb begin
    prod_s = qneg_q ? -acc_q : acc_q;
    quo_s  = qneg_q ? -acc_q[WIDTH-1:0]
                    : acc_q[WIDTH-1:0];
    rem_s  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                    : acc_q[2*WIDTH-1:WIDTH];
  end

  // Control FSM with registered status, HI/LO and step state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mc_q    <= '0;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dzp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            div_q  <= is_div;
            qneg_q <= s1 ^ s2;
            rneg_q <= s1 & is_div;
            dzp_q  <= zdiv;
            dz_q   <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (is_div) begin
              mc_q  <= mag2;
              acc_q <= {{WIDTH{1'b0}}, mag1};
            end else begin
              mc_q  <= mag1;
              acc_q <= {{WIDTH{1'b0}}, mag2};
            end
            state_q <= zdiv ? FIX : CALC;
          end else begin
            if (bus.wr_hi) hi_q <= bus.wr_data;
            if (bus.wr_lo) lo_q <= bus.wr_data;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (dzp_q) begin
            hi_q <= '0;
            lo_q <= '0;
            dz_q <= 1'b1;
          end else if (div_q) begin
            hi_q <= rem_s;
            lo_q <= quo_s;
          end else begin
            hi_q <= prod_s[2*WIDTH-1:WIDTH];
            lo_q <= prod_s[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.dz   = dz_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: vector table, random ops vs arithmetic model, corner sequences.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_muldiv_ctrl;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  muldiv_ctrl_if #(.WIDTH(W)) bus ();

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  localparam logic [3:0] MULTU = 4'b1100;
  localparam logic [3:0] DIVU  = 4'b1101;
  localparam logic [3:0] MULT  = 4'b1110;
  localparam logic [3:0] DIV   = 4'b1111;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [3:0] o,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] eh,
                                output logic [31:0] el,
                                output logic edz);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [63:0] tq;
    logic [63:0] tr;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    edz = 1'b0;
    eh  = '0;
    el  = '0;
    case (o)
      MULTU: begin
        p  = {32'b0, a} * {32'b0, b};
        eh = p[63:32];
        el = p[31:0];
      end
      MULT: begin
        p  = sa * sb;
        eh = p[63:32];
        el = p[31:0];
      end
      DIVU: begin
        if (b == 0) edz = 1'b1;
        else begin
          el = a / b;
          eh = a % b;
        end
      end
      default: begin
        if (b == 0) edz = 1'b1;
        else begin
          tq = sa / sb;
          tr = sa % sb;
          el = tq[31:0];
          eh = tr[31:0];
        end
      end
    endcase
  endfunction

  task automatic issue(input logic [3:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.in1   = a;
    bus.in2   = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done; optionally injects a start+wr_hi at cycle inj.
  task automatic wait_done(input int inj,
                           input logic [3:0] io,
                           input logic [31:0] ia,
                           input logic [31:0] ib,
                           input logic iwh,
                           output int nb,
                           output bit seen);
    int n;
    n    = 1;
    nb   = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      if (bus.done) seen = 1'b1;
      else begin
        if (bus.busy) nb++;
        bus.start = (n == inj);
        bus.wr_hi = (n == inj) && iwh;
        if (n == inj) begin
          bus.op      = io;
          bus.in1     = ia;
          bus.in2     = ib;
          bus.wr_data = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        n++;
      end
    end
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
  endtask

  task automatic finish_chk(input string nm,
                            input int nb,
                            input bit seen,
                            input logic [31:0] eh,
                            input logic [31:0] el,
                            input logic edz);
    chk({nm, " done seen"}, 64'(seen), 64'd1);
    chk({nm, " busy cycles"}, 64'(nb),
        edz ? 64'd1 : 64'(W + 1));
    chk({nm, " busy at done"}, 64'(bus.busy), 64'd0);
    chk({nm, " hi"}, 64'(bus.hi), 64'(eh));
    chk({nm, " lo"}, 64'(bus.lo), 64'(el));
    chk({nm, " dz"}, 64'(bus.dz), 64'(edz));
    @(negedge clk);
    chk({nm, " done width"}, 64'(bus.done), 64'd0);
    chk({nm, " hi held"}, 64'(bus.hi), 64'(eh));
  endtask

  task automatic run_vec(input string nm,
                         input logic [3:0] o,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] eh,
                         input logic [31:0] el,
                         input logic edz);
    int nb;
    bit seen;
    issue(o, a, b);
    wait_done(0, 4'h0, 32'h0, 32'h0, 1'b0, nb, seen);
    finish_chk(nm, nb, seen, eh, el, edz);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs[12];

  initial begin
    int          nb;
    bit          seen;
    int          dseen;
    logic [3:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] eh;
    logic [31:0] el;
    logic        edz;

    checks = 0;
    errors = 0;
    vecs[0]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{MULT, 32'hFFFF_FFFD, 32'd7,
                 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{DIV, 32'hFFFF_FFF9, 32'd2,
                 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{DIVU, 32'd5, 32'd0, 32'h0, 32'h0, 1'b1};
    vecs[4]  = '{MULTU, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0};
    vecs[5]  = '{DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                 32'h0, 32'h8000_0000, 1'b0};
    vecs[6]  = '{DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
    vecs[7]  = '{DIV, 32'd7, 32'hFFFF_FFFE,
                 32'd1, 32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{MULT, 32'h8000_0000, 32'h8000_0000,
                 32'h4000_0000, 32'h0, 1'b0};
    vecs[9]  = '{MULT, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0};
    vecs[10] = '{DIV, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[11] = '{DIVU, 32'hFFFF_FFFF, 32'd1,
                 32'h0, 32'hFFFF_FFFF, 1'b0};

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.op      = '0;
    bus.in1     = '0;
    bus.in2     = '0;
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b0;
    bus.wr_data = '0;
    repeat (2) @(negedge clk);
    chk("reset state",
        {27'b0, bus.busy, bus.done, bus.dz, 2'b0, bus.hi | bus.lo},
        64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a,
              vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);
    end

    for (int i = 0; i < 40; i++) begin
      ro = 4'b1100 | 4'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      model(ro, ra, rb, eh, el, edz);
      run_vec($sformatf("rand%0d op%h %h %h", i, ro, ra, rb),
              ro, ra, rb, eh, el, edz);
    end

    // Second start mid-operation is ignored.
    issue(MULTU, 32'd4, 32'd5);
    wait_done(5, DIV, 32'd9, 32'd3, 1'b0, nb, seen);
    finish_chk("restart ignored", nb, seen, 32'h0, 32'd20, 1'b0);

    // Idle HI/LO writes.
    @(negedge clk);
    bus.wr_hi   = 1'b1;
    bus.wr_data = 32'h1234;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    chk("mthi", 64'(bus.hi), 64'h1234);
    bus.wr_hi   = 1'b1;
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'hABCD;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    chk("mthi+mtlo hi", 64'(bus.hi), 64'hABCD);
    chk("mthi+mtlo lo", 64'(bus.lo), 64'hABCD);

    // Invalid op: start dropped, write still lands.
    bus.start   = 1'b1;
    bus.op      = 4'b0101;
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'h55;
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_lo = 1'b0;
    chk("bad op busy", 64'(bus.busy), 64'd0);
    chk("bad op mtlo", 64'(bus.lo), 64'h55);

    // Start wins over same-cycle write; writes while busy ignored.
    bus.start   = 1'b1;
    bus.op      = MULTU;
    bus.in1     = 32'd3;
    bus.in2     = 32'd4;
    bus.wr_hi   = 1'b1;
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'hDEAD;
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    chk("start wins hi", 64'(bus.hi), 64'hABCD);
    chk("start busy", 64'(bus.busy), 64'd1);
    wait_done(10, MULTU, 32'd9, 32'd9, 1'b1, nb, seen);
    finish_chk("start wins", nb, seen, 32'h0, 32'd12, 1'b0);

    // Reset in the middle of a mult.
    @(negedge clk);
    bus.wr_hi   = 1'b1;
    bus.wr_lo   = 1'b1;
    bus.wr_data = 32'hAAAA_5555;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    issue(MULT, 32'hFFFF_FFFD, 32'd7);
    repeat (9) @(negedge clk);
    chk("pre-reset busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset",
        {27'b0, bus.busy, bus.done, bus.dz, 2'b0, bus.hi | bus.lo},
        64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dseen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dseen++;
    end
    chk("no done after reset", 64'(dseen), 64'd0);
    run_vec("post-reset", MULT, 32'hFFFF_FFFD, 32'd7,
            32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin an operation; accepted only when busy=0.
REQ-005 SHALL have port op  input  4  operation code: 1100 multu, 1101 divu, 1110 mult, 1111 div.
REQ-006 SHALL have port in1  input  WIDTH  rs operand; multiplicand, or dividend.
REQ-007 SHALL have port in2  input  WIDTH  rt operand; multiplier, or divisor.
REQ-008 SHALL have port wr_hi  input  1  write wr_data into HI (mthi).
REQ-009 SHALL have port wr_lo  input  1  write wr_data into LO (mtlo).
REQ-010 SHALL have port wr_data  input  WIDTH  data for HI/LO writes.
REQ-011 SHALL have port busy  output  1  operation in progress; the pipeline stalls mfhi/mflo/start while it is high.
REQ-012 SHALL have port done  output  1  one-cycle pulse; hi/lo hold a new result.
REQ-013 SHALL have port hi  output  WIDTH  HI register: product upper half, or remainder.
REQ-014 SHALL have port lo  output  WIDTH  LO register: product lower half, or quotient.
REQ-015 SHALL have port dz  output  1  divide-by-zero flag; cleared on the next accepted start.

Function
REQ-016 SHALL implement a FSM with states IDLE, CALC and FIX; busy=1 exactly in CALC and FIX.
REQ-017 SHALL accept when start=1, busy=0 and op[3:2]=11 (edge E0): latch operand magnitudes and sign info, clear dz, enter CALC with iteration counter=0.
REQ-018 SHALL silently ignore start when op[3:2]!=11 or busy=1 (no state change).
REQ-019 SHALL treat operands as two's complement for mult/div and as unsigned for multu/divu.
REQ-020 SHALL perform one shift-add multiply or one restoring-divide step per CALC cycle, for exactly WIDTH cycles, then enter FIX.
REQ-021 SHALL, in FIX, apply sign correction, write hi/lo, pulse done for one cycle, and return to IDLE.
REQ-022 SHALL produce the result at edge E0+WIDTH+1 (33 for WIDTH=32); busy=0 and done=1 in the following cycle.
REQ-023 Multiply result: {hi,lo} = full 2*WIDTH-bit product; negated when operand signs differ (signed only).
REQ-024 Divide result: lo = in1/in2 truncated toward zero; hi = remainder with the sign of in1 (signed div).
REQ-025 Signed div of most-negative by -1: lo=0x80000000, hi=0, no flag.
REQ-026 SHALL, on divu/div with in2=0, skip CALC: at E1 set hi=0, lo=0, dz=1, done=1, busy=0.
REQ-027 SHALL not shortcut zero-operand multiplies; latency stays fixed.
REQ-028 In IDLE without an accepted start: wr_hi/wr_lo update hi/lo at the clock edge; both may fire in the same cycle.
REQ-029 SHALL ignore wr_hi/wr_lo while busy=1, and in a cycle where a start is accepted (the start wins).
REQ-030 hi/lo SHALL hold their values between updates; mid-operation partial results SHALL NOT appear on hi/lo.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force the state to IDLE and set busy=0, done=0, dz=0, hi=0, lo=0, with the counter cleared.
REQ-032 SHALL, on reset mid-operation, abort the operation with no done pulse; the first start after rst_n rises is processed normally.

Verification
REQ-033 multu 0xFFFFFFFF*0xFFFFFFFF -> busy high 33 cycles; hi=0xFFFFFFFE, lo=0x00000001; done high exactly 1 cycle.
REQ-034 mult 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; div 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 divu 5/0 -> done at E1, hi=0, lo=0, dz=1; a following multu 2*3 clears dz, giving lo=6, hi=0.
REQ-036 start multu 4*5, re-assert start with div 9/3 at cycle 5 -> second start ignored; result lo=20, hi=0.
REQ-037 rst_n low at cycle 10 of a mult -> hi=lo=busy=done=0 immediately; no done pulse after release.
REQ-038 idle: wr_hi=1, wr_data=0x1234 -> hi=0x1234; same cycle as an accepted start -> write dropped, hi=multiply result.
